// File: rtl/line_buf_window_ctrl.sv
// line_buf_window_ctrl: sequences the two-line shift RAM pair and assembles a 3x3 pixel window
// with 2-cycle delay-matched syncs, a window-valid flag and per-frame row/column tracking.
module line_buf_window_ctrl #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480,
   parameter int DW    = 8
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic          per_frame_vsync,
   input  logic          per_frame_href,
   input  logic          per_frame_clken,
   input  logic [DW-1:0] per_img_y,
   output logic          ram_clken,
   output logic          ram_href,
   output logic [DW-1:0] ram_shiftin,
   input  logic [DW-1:0] ram_taps0x,
   input  logic [DW-1:0] ram_taps1x,
   output logic [DW-1:0] matrix_p11,
   output logic [DW-1:0] matrix_p12,
   output logic [DW-1:0] matrix_p13,
   output logic [DW-1:0] matrix_p21,
   output logic [DW-1:0] matrix_p22,
   output logic [DW-1:0] matrix_p23,
   output logic [DW-1:0] matrix_p31,
   output logic [DW-1:0] matrix_p32,
   output logic [DW-1:0] matrix_p33,
   output logic          matrix_frame_vsync,
   output logic          matrix_frame_href,
   output logic          matrix_frame_clken,
   output logic          window_valid,
   output logic [9:0]    row_cnt,
   output logic [9:0]    col_cnt,
   output logic          line_ovf
);
   localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, ACTIVE = 2'd2, DONE = 2'd3;
   localparam logic [10:0] W = 11'(IMG_W);
   localparam logic [9:0] H = 10'(IMG_H);

   logic [1:0]    state, vsync_d, href_d, clken_d;
   logic          valid_d, frame_start, href_fall, in_line, win_pre;
   logic [DW-1:0] pix_d;

   assign frame_start = per_frame_vsync & ~vsync_d[0];
   assign href_fall   = href_d[0] & ~per_frame_href;
   assign in_line     = {1'b0, col_cnt} < W;
   assign ram_clken   = per_frame_clken & per_frame_href & in_line & (state != IDLE);
   assign ram_href    = per_frame_href;
   assign ram_shiftin = per_img_y;
   // the current pixel's own row/col decide validity; it is then delayed to meet its window
   assign win_pre = per_frame_clken & per_frame_href & ~frame_start & (state == ACTIVE || state == DONE)
                  & (col_cnt >= 10'd2) & in_line;
   assign matrix_frame_vsync = vsync_d[1];
   assign matrix_frame_href  = href_d[1];
   assign matrix_frame_clken = clken_d[1];

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state        <= IDLE;
         vsync_d      <= '0;
         href_d       <= '0;
         clken_d      <= '0;
         valid_d      <= 1'b0;
         window_valid <= 1'b0;
         row_cnt      <= '0;
         col_cnt      <= '0;
         line_ovf     <= 1'b0;
         pix_d        <= '0;
      end else begin
         state <= frame_start ? FILL :
                  (state == FILL && href_fall && row_cnt == 10'd1) ? ACTIVE :
                  (state == ACTIVE && href_fall && row_cnt >= H - 10'd1) ? DONE : state;
         vsync_d      <= {vsync_d[0], per_frame_vsync};
         href_d       <= {href_d[0], per_frame_href};
         clken_d      <= {clken_d[0], per_frame_clken};
         valid_d      <= win_pre;
         window_valid <= valid_d;
         pix_d        <= per_img_y;
         col_cnt  <= (frame_start || !per_frame_href) ? 10'd0 :
                     (per_frame_clken && col_cnt != 10'h3ff) ? col_cnt + 10'd1 : col_cnt;
         row_cnt  <= frame_start ? 10'd0 : (href_fall && row_cnt < H) ? row_cnt + 10'd1 : row_cnt;
         line_ovf <= frame_start ? 1'b0 : line_ovf | (per_frame_href & per_frame_clken & ~in_line);
      end
   end

   // taps are valid the cycle after ram_clken, so the window shifts on the once-delayed strobe
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         {matrix_p11, matrix_p12, matrix_p13} <= '0;
         {matrix_p21, matrix_p22, matrix_p23} <= '0;
         {matrix_p31, matrix_p32, matrix_p33} <= '0;
      end else if (clken_d[0]) begin
         {matrix_p11, matrix_p12, matrix_p13} <= {matrix_p12, matrix_p13, ram_taps1x};
         {matrix_p21, matrix_p22, matrix_p23} <= {matrix_p22, matrix_p23, ram_taps0x};
         {matrix_p31, matrix_p32, matrix_p33} <= {matrix_p32, matrix_p33, pix_d};
      end
   end
endmodule

// File: tb/tb_line_buf_window_ctrl.sv
// tb_line_buf_window_ctrl: random frames through a shift-RAM emulator, windows checked against
// expectations built from the stored image (every 3x3 neighbourhood with row>=2, 2<=col<W).
module tb_line_buf_window_ctrl;
   localparam int W = 8, H = 4;
   logic       clock = 0, rst_n = 0, vsync = 0, href = 0, clken = 0;
   logic [7:0] y = 0, shiftin, taps0 = 0, taps1 = 0;
   logic       ram_clken, ram_href, mvs, mhref, mclk, window_valid, line_ovf;
   logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic [9:0] row_cnt, col_cnt;
   int         total = 0, bad = 0, cyc = 0, vcount = 0, addr = 0;
   logic       mon_on = 0;
   logic [7:0] line0 [1024];
   logic [7:0] line1 [1024];
   logic [7:0] pix [8][16];
   typedef struct { int due; logic [71:0] win; } exp_t;
   exp_t q[$];

   line_buf_window_ctrl #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
      .clock(clock), .rst_n(rst_n), .per_frame_vsync(vsync), .per_frame_href(href),
      .per_frame_clken(clken), .per_img_y(y), .ram_clken(ram_clken), .ram_href(ram_href),
      .ram_shiftin(shiftin), .ram_taps0x(taps0), .ram_taps1x(taps1),
      .matrix_p11(p11), .matrix_p12(p12), .matrix_p13(p13), .matrix_p21(p21), .matrix_p22(p22),
      .matrix_p23(p23), .matrix_p31(p31), .matrix_p32(p32), .matrix_p33(p33),
      .matrix_frame_vsync(mvs), .matrix_frame_href(mhref), .matrix_frame_clken(mclk),
      .window_valid(window_valid), .row_cnt(row_cnt), .col_cnt(col_cnt), .line_ovf(line_ovf));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // two-line shift RAM emulator: address clears while href is low
   always @(posedge clock) begin
      if (!ram_href) addr <= 0;
      else if (ram_clken) begin
         taps0 <= line0[addr];
         taps1 <= line1[addr];
         line1[addr] <= line0[addr];
         line0[addr] <= shiftin;
         addr <= addr + 1;
      end
   end

   task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   always @(negedge clock) begin
      logic e;
      if (mon_on) begin
         e = q.size() > 0 && q[0].due == cyc;
         chk("valid", window_valid, e);
         chk("valid_vs_clken", window_valid & ~mclk, 1'b0);
         if (window_valid) vcount++;
         if (e) begin
            if (window_valid) chk("window", {p11, p12, p13, p21, p22, p23, p31, p32, p33}, q[0].win);
            void'(q.pop_front());
         end
      end
   end

   task automatic drive(input logic vs, input logic hr, input logic ck, input logic [7:0] px);
      @(posedge clock);
      #1;
      vsync = vs; href = hr; clken = ck; y = px;
   endtask

   // mode 0: continuous clken, 1: every other cycle, 2: random; modes 0/1 use pixel=row*16+col
   // ev_kind 1: vsync rise at (ev_row,ev_col); 2: reset pulse there
   task automatic send_frame(input int mode, input int ovf_row, input int ev_row, input int ev_col,
                             input int ev_kind);
      logic ph = 0, strobe, dead = 0, rst_dead = 0, chk_vs = 0;
      logic [7:0] px;
      int n, c;
      drive(1, 0, 0, 0); drive(1, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);
      chk("ovf_clr", line_ovf, 1'b0);
      chk("row_start", row_cnt, 10'd0);
      for (int r = 0; r < H + 3; r++) begin
         if (!dead && r == H) break;
         if (dead && r > ev_row + ev_kind) break;
         n = (r == ovf_row) ? W + 2 : W;
         c = 0;
         while (c < n) begin
            strobe = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
            ph = ~ph;
            if (!strobe) begin
               drive(0, 1, 0, 8'($urandom));
               continue;
            end
            if (ev_kind == 2 && !dead && r == ev_row && c == ev_col) begin
               rst_n = 0;
               drive(0, 1, 0, 8'($urandom));
               while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
               dead = 1; rst_dead = 1;
               rst_n = 1;
               drive(0, 1, 0, 8'($urandom));
               chk("rst_valid", window_valid, 1'b0);
               chk("rst_win", {p11, p22, p33, mclk, mhref}, '0);
               chk("rst_cnt", {row_cnt, col_cnt, line_ovf}, '0);
               continue;
            end
            px = (mode < 2) ? 8'(r * 16 + c) : 8'($urandom);
            pix[r][c] = px;
            drive(ev_kind == 1 && !dead && r == ev_row && c == ev_col, 1, 1, px);
            if (chk_vs) begin
               chk("vs_row", row_cnt, 10'd0);
               chk("vs_col", col_cnt, 10'd0);
               chk_vs = 0;
            end
            if (ev_kind == 1 && !dead && r == ev_row && c == ev_col) begin
               dead = 1; chk_vs = 1;
            end
            if (!dead && r >= 2 && c >= 2 && c < W)
               q.push_back('{cyc + 2, {pix[r-2][c-2], pix[r-2][c-1], pix[r-2][c],
                                      pix[r-1][c-2], pix[r-1][c-1], pix[r-1][c],
                                      pix[r][c-2], pix[r][c-1], pix[r][c]}});
            #1;
            chk("ram_clken", ram_clken, c < W && !rst_dead);
            c++;
         end
         drive(0, 0, 0, 0);
         drive(0, 0, 0, 0);
         if (!dead) chk("row_cnt", row_cnt, 10'(r + 1));
         chk("line_ovf", line_ovf, ovf_row >= 0 && r >= ovf_row);
         drive(0, 0, 0, 0);
      end
      repeat (4) drive(0, 0, 0, 0);
   endtask

   initial begin
      repeat (3) drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
      drive(0, 1, 1, 8'h5a);
      #1;
      chk("reset_ram_clken", ram_clken, 1'b0);
      chk("reset_valid", {window_valid, mclk, mhref, mvs}, '0);
      chk("reset_win", {p11, p12, p13, p21, p22, p23, p31, p32, p33}, '0);
      chk("reset_cnt", {row_cnt, col_cnt, line_ovf}, '0);
      rst_n = 1;
      drive(0, 0, 0, 0); drive(0, 0, 0, 0);
      mon_on = 1;
      vcount = 0;
      send_frame(0, -1, -1, -1, 0);
      chk("nvalid_cont", vcount, 12);
      vcount = 0;
      send_frame(1, -1, -1, -1, 0);
      chk("nvalid_alt", vcount, 12);
      send_frame(2, 2, -1, -1, 0);
      send_frame(2, -1, 3, 5, 1);
      send_frame(0, -1, 2, 3, 2);
      vcount = 0;
      send_frame(2, -1, -1, -1, 0);
      chk("nvalid_rand", vcount, 12);
      send_frame(2, -1, -1, -1, 0);
      repeat (4) drive(0, 0, 0, 0);
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
